// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad scanner with press/release debounce
// Rev 1.0
// ============================================================================
module keypad_scanner #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1khz,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int            CW      = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] C_TICKS = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic          clk1k_meta_q, clk1k_sync_q, clk1k_prev_q;
  logic [3:0]    col_meta_q, col_sync_q;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    cap_col_q, cap_col_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;

  logic          w_tick;
  logic          w_idle;
  logic          w_single;
  logic [1:0]    w_col_idx;
  logic [CW-1:0] w_cnt_inc;

  // clk_1khz is only sampled as data; its synced rising edge is the scan tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk1k_meta_q <= 1'b0;
      clk1k_sync_q <= 1'b0;
      clk1k_prev_q <= 1'b0;
      col_meta_q   <= 4'd0;
      col_sync_q   <= 4'd0;
    end else begin
      clk1k_meta_q <= clk_1khz;
      clk1k_sync_q <= clk1k_meta_q;
      clk1k_prev_q <= clk1k_sync_q;
      col_meta_q   <= col_n;
      col_sync_q   <= col_meta_q;
    end
  end

  assign w_tick    = clk1k_sync_q & ~clk1k_prev_q;
  assign w_idle    = (col_sync_q == 4'b1111);
  assign w_cnt_inc = cnt_q + C_ONE;

  always_comb begin
    w_single  = 1'b1;
    w_col_idx = 2'd0;
    case (col_sync_q)
      4'b1110: w_col_idx = 2'd0;
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_single  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SCAN;
      cnt_q     <= '0;
      row_q     <= 2'd0;
      pat_q     <= 4'hF;
      cap_col_q <= 2'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      cap_col_q <= cap_col_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
    end
  end

  // The row stays held from detection until release completes, so row_q is the captured row
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    pat_d     = pat_q;
    cap_col_d = cap_col_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    down_d    = down_q;
    if (w_tick) begin
      case (state_q)
        S_SCAN: begin
          if (w_single) begin
            pat_d     = col_sync_q;
            cap_col_d = w_col_idx;
            cnt_d     = '0;
            state_d   = S_DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (col_sync_q == pat_q) begin
            if (w_cnt_inc == C_TICKS) begin
              code_d  = {row_q, cap_col_q};
              valid_d = 1'b1;
              down_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = S_SCAN;
          end
        end
        S_HOLD: begin
          if (w_idle) begin
            cnt_d   = '0;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_idle) begin
            if (w_cnt_inc == C_TICKS) begin
              down_d  = 1'b0;
              cnt_d   = '0;
              row_d   = row_q + 2'd1;
              state_d = S_SCAN;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      endcase
    end
  end

  always_comb begin
    row_n     = ~(4'b0001 << row_q);
    key_valid = valid_q;
    key_code  = code_q;
    key_down  = down_q;
  end

endmodule
`default_nettype wire
